// File: rtl/barrel_shift_pipe.sv
// -----------------------------------------------------------------------------
// barrel_shift_pipe
//   Pipelined barrel shifter. Stage k shifts by 2^k when bit k of the shift
//   amount is set, so a full shift takes SHW register stages. The whole
//   pipeline advances together and freezes together when the result at the
//   output is not taken.
//
// Handshake (both sides): a transfer happens at a rising edge where valid and
//   ready are both 1. valid, once raised by the producer, carries the same
//   payload until the transfer. in_ready is a pure function of out_valid and
//   out_ready and never looks at in_valid.
//
// Ports
//   clk        clock, all state on the rising edge
//   rst        synchronous active-high reset
//   in_valid   source offers an operation
//   in_ready   block can accept this cycle (= !stall)
//   in_data    operand
//   in_amt     shift amount, only bits [SHW-1:0] are used
//   in_op      00 SLL, 01 SRL, 10 SRA, 11 ROR
//   out_valid  out_data holds a finished result
//   out_ready  sink takes the result this cycle
//   out_data   result, forced to 0 while out_valid is 0
//   out_zero   result is all zeros (only while out_valid)
// -----------------------------------------------------------------------------
module barrel_shift_pipe #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [WIDTH-1:0] in_amt,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero
);

  localparam int LAST = SHW - 1;

  // One fixed-distance step. sh is always 2^k with k < SHW, so it is
  // between 1 and WIDTH/2 and the rotate's left shift never reaches WIDTH.
  function automatic logic [WIDTH-1:0] shift_step(
    input logic [WIDTH-1:0] d,
    input logic [1:0]       op,
    input logic             sign,
    input int               sh
  );
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] fill;
    fill = sign ? ~({WIDTH{1'b1}} >> sh) : '0;
    case (op)
      2'b00:   r = d << sh;
      2'b01:   r = d >> sh;
      2'b10:   r = (d >> sh) | fill;
      default: r = (d >> sh) | (d << (WIDTH - sh));
    endcase
    return r;
  endfunction

  // Stage registers
  logic             st_valid [SHW];
  logic [WIDTH-1:0] st_data  [SHW];
  logic [1:0]       st_op    [SHW];
  logic [SHW-1:0]   st_amt   [SHW];
  // Operand MSB captured at accept; SRA fills from this, never from the
  // partially shifted data of later stages.
  logic             st_sign  [SHW];

  // Inputs seen by each stage: stage 0 looks at the port, stage k at k-1.
  logic             p_valid [SHW];
  logic [WIDTH-1:0] p_data  [SHW];
  logic [1:0]       p_op    [SHW];
  logic [SHW-1:0]   p_amt   [SHW];
  logic             p_sign  [SHW];

  logic stall;

  assign p_valid[0] = in_valid;
  assign p_data[0]  = in_data;
  assign p_op[0]    = in_op;
  assign p_amt[0]   = in_amt[SHW-1:0];
  assign p_sign[0]  = in_data[WIDTH-1];

  for (genvar g = 1; g < SHW; g++) begin : g_link
    assign p_valid[g] = st_valid[g-1];
    assign p_data[g]  = st_data[g-1];
    assign p_op[g]    = st_op[g-1];
    assign p_amt[g]   = st_amt[g-1];
    assign p_sign[g]  = st_sign[g-1];
  end

  assign out_valid = st_valid[LAST];
  assign stall     = out_valid && !out_ready;
  assign in_ready  = !stall;
  assign out_data  = out_valid ? st_data[LAST] : '0;
  assign out_zero  = out_valid && (out_data == '0);

  // The whole pipe moves as one: bubbles are kept in place during a stall,
  // which keeps in_ready a single-gate function of the output side.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < SHW; k++) begin
        st_valid[k] <= 1'b0;
        st_data[k]  <= '0;
        st_op[k]    <= '0;
        st_amt[k]   <= '0;
        st_sign[k]  <= 1'b0;
      end
    end else if (!stall) begin
      for (int k = 0; k < SHW; k++) begin
        st_valid[k] <= p_valid[k];
        if (p_valid[k]) begin
          st_data[k] <= p_amt[k][k] ?
                        shift_step(p_data[k], p_op[k], p_sign[k], 1 << k) :
                        p_data[k];
          st_op[k]   <= p_op[k];
          st_amt[k]  <= p_amt[k];
          st_sign[k] <= p_sign[k];
        end else begin
          // Bubbles carry zeros so nothing stale lingers in the data path.
          st_data[k] <= '0;
          st_op[k]   <= '0;
          st_amt[k]  <= '0;
          st_sign[k] <= 1'b0;
        end
      end
    end
  end

  // Upper amount bits are ignored (amount wraps modulo WIDTH) and the last
  // stage's control fields have no consumer.
  logic unused_bits;
  assign unused_bits = ^{in_amt[WIDTH-1:SHW], st_op[LAST], st_amt[LAST],
                         st_sign[LAST]};

endmodule

// File: tb/tb_barrel_shift_pipe.sv
// -----------------------------------------------------------------------------
// tb_barrel_shift_pipe
//   Directed checks of barrel_shift_pipe (WIDTH=32) with a scoreboard: the
//   driver pushes the hand-computed result when an operation is accepted and
//   an independent monitor pops and compares whenever a result is handed off.
//   A short randomised phase with random gaps and random out_ready closes it.
// -----------------------------------------------------------------------------
module tb_barrel_shift_pipe;

  localparam int W = 32;
  localparam logic [1:0] SLL = 2'b00, SRL = 2'b01, SRA = 2'b10, ROR = 2'b11;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic [W-1:0] in_amt = '0;
  logic [1:0]   in_op = 2'b00;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_data;
  logic         out_zero;

  logic [W-1:0] exp_q[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int acc_cyc = 0;
  bit bp_done = 1'b0;
  bit rnd_done = 1'b0;

  barrel_shift_pipe #(.WIDTH(W), .SHW(5)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_amt(in_amt), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_zero(out_zero)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model written straight from the operation definitions.
  function automatic logic [W-1:0] ref_shift(input logic [1:0] op,
                                             input logic [W-1:0] d,
                                             input logic [W-1:0] amt);
    int a;
    a = int'(amt[4:0]);
    case (op)
      SLL: return d << a;
      SRL: return d >> a;
      SRA: return W'($signed(d) >>> a);
      default: return (a == 0) ? d : ((d >> a) | (d << (W - a)));
    endcase
  endfunction

  // Driver: called just after a rising edge. Holds the op until in_ready is
  // seen mid-cycle (so the accept lands on the next edge), then drops valid.
  task automatic send(input logic [1:0] op, input logic [W-1:0] d,
                      input logic [W-1:0] amt, input logic [W-1:0] exp,
                      input bit push);
    int waited;
    in_valid = 1'b1;
    in_op    = op;
    in_data  = d;
    in_amt   = amt;
    waited   = 0;
    @(negedge clk);
    while (!in_ready && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got in_ready=0, expected 1 within 300 cycles");
    end else begin
      if (push) exp_q.push_back(exp);
      acc_cyc = cyc;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_empty(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(name, W'(exp_q.size()), '0);
  endtask

  // Wait (bounded) for out_valid mid-cycle and return cycles since accept.
  task automatic wait_out(output int lat);
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    lat = out_valid ? (cyc - acc_cyc) : -1;
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (!out_valid) begin
        if (out_data !== '0 || out_zero !== 1'b0)
          check("idle_outputs", {out_data[W-2:0], out_zero}, '0);
      end else if (out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", out_data, 'x);
        end else begin
          logic [W-1:0] e;
          e = exp_q.pop_front();
          check("result", out_data, e);
          check("out_zero", W'(out_zero), W'(e == '0));
        end
      end
    end
  end

  initial begin : main
    int lat;
    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", W'(out_valid), '0);
    check("rst_out_data", out_data, '0);
    check("rst_out_zero", W'(out_zero), '0);
    check("rst_in_ready", W'(in_ready), 32'd1);
    rst = 1'b0;

    // SRL 0x80000000 by 31, latency 5
    send(SRL, 32'h8000_0000, 32'd31, 32'h0000_0001, 1'b1);
    wait_out(lat);
    check("srl_latency", W'(lat), 32'd5);
    check("srl_data", out_data, 32'h0000_0001);
    wait_empty("drain_srl");

    // SRA then ROR back to back, results on consecutive cycles
    send(SRA, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b1);
    send(ROR, 32'h1234_5678, 32'd8, 32'h7812_3456, 1'b1);
    wait_out(lat);
    check("sra_first", out_data, 32'hF800_0000);
    @(negedge clk);
    check("ror_next_cycle_valid", W'(out_valid), 32'd1);
    check("ror_next_cycle", out_data, 32'h7812_3456);
    wait_empty("drain_sra_ror");

    // amount wrap, zero flag, amount 0, assorted fills
    send(SLL, 32'h0000_0001, 32'd33, 32'h0000_0002, 1'b1);
    send(SLL, 32'h8000_0000, 32'd1,  32'h0000_0000, 1'b1);
    send(SLL, 32'hA5A5_A5A5, 32'd0,  32'hA5A5_A5A5, 1'b1);
    send(SRL, 32'hA5A5_A5A5, 32'd0,  32'hA5A5_A5A5, 1'b1);
    send(SRA, 32'hA5A5_A5A5, 32'd0,  32'hA5A5_A5A5, 1'b1);
    send(ROR, 32'hA5A5_A5A5, 32'd0,  32'hA5A5_A5A5, 1'b1);
    send(SRA, 32'h7FFF_FFF0, 32'd4,  32'h07FF_FFFF, 1'b1);
    send(ROR, 32'h0000_0001, 32'd1,  32'h8000_0000, 1'b1);
    send(SRL, 32'hFFFF_FFFF, 32'd32, 32'hFFFF_FFFF, 1'b1);
    send(SRA, 32'h8000_0001, 32'd31, 32'hFFFF_FFFF, 1'b1);
    send(SLL, 32'h0000_ABCD, 32'd16, 32'hABCD_0000, 1'b1);
    send(ROR, 32'h8765_4321, 32'd36, 32'h1876_5432, 1'b1);
    wait_empty("drain_directed");

    // backpressure: 8 ops with the sink blocked
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          logic [W-1:0] one;
          one = 32'h1;
          send(SLL, one, W'(i), one << i, 1'b1);
        end
        bp_done = 1'b1;
      end
    join_none
    idle(12);
    check("bp_in_ready_low", W'(in_ready), '0);
    check("bp_out_valid", W'(out_valid), 32'd1);
    check("bp_out_data_held", out_data, 32'h0000_0001);
    out_ready = 1'b1;
    begin
      int n;
      n = 0;
      while (!bp_done && n < 200) begin
        idle(1);
        n++;
      end
    end
    check("bp_sender_done", W'(bp_done), 32'd1);
    wait_empty("drain_bp");

    // reset with three ops in flight; nothing of them may surface
    send(SLL, 32'h1111_1111, 32'd1, '0, 1'b0);
    send(SRL, 32'h2222_2222, 32'd2, '0, 1'b0);
    send(ROR, 32'h3333_3333, 32'd3, '0, 1'b0);
    rst = 1'b1;
    idle(1);
    check("midrst_out_valid", W'(out_valid), '0);
    check("midrst_in_ready", W'(in_ready), 32'd1);
    rst = 1'b0;
    send(SRA, 32'hF000_000F, 32'd8, 32'hFFF0_0000, 1'b1);
    wait_out(lat);
    check("post_rst_latency", W'(lat), 32'd5);
    check("post_rst_data", out_data, 32'hFFF0_0000);
    wait_empty("drain_post_rst");
    idle(8);

    // random traffic with random sink readiness
    fork
      begin
        for (int i = 0; i < 400; i++) begin
          logic [1:0]   op;
          logic [W-1:0] d;
          logic [W-1:0] a;
          if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
          op = 2'($urandom_range(0, 3));
          d  = $urandom;
          a  = $urandom;
          send(op, d, a, ref_shift(op, d, a), 1'b1);
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 2) != 0);
        end
        out_ready = 1'b1;
      end
    join
    wait_empty("drain_random");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "timeout");
  end

endmodule
